// File: rtl/okand_pkg.sv
// okand_pkg: shared widths and drain FSM state type for the okand result collector.
package okand_pkg;
    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {IDLE, LO, HI} drain_state_t;
endpackage

// File: rtl/okand_sync_fifo.sv
// okand_sync_fifo: first-word-fall-through FIFO; accepts a push on a full FIFO when the same edge pops.
module okand_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic wr_en;

    assign rd_nxt = rd_ptr + 1'b1;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr_en = push && (!full || pop);
    assign head = mem[rd_ptr];
    // Lets the reader present the following word in the same cycle it pops the head.
    assign head_next = mem[rd_nxt];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_nxt;
            count <= (wr_en && !pop) ? count + 1'b1 : (!wr_en && pop) ? count - 1'b1 : count;
        end
    end
endmodule

// File: rtl/okand_result_collector.sv
// okand_result_collector: deserializes 16-bit LSB-first result bursts, buffers them,
// and drains each word as a low/high byte pair over a valid/ready interface.
module okand_result_collector
    import okand_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   pc_clk,
    input  logic                   pc_rst,
    input  logic                   fpga_data,
    input  logic                   fpga_valid,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic [$clog2(DEPTH):0] word_count,
    output logic                   overflow,
    output logic                   frame_err
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0] bit_cnt;
    logic [WORD_W-2:0] shreg;
    logic [WORD_W-1:0] push_word, head, head_next;
    logic push, pop, full, empty, hs, more, many;
    drain_state_t state, state_d;
    logic [BYTE_W-1:0] data_d;
    logic valid_d;

    assign push = fpga_valid && bit_cnt == 4'd15;
    assign push_word = {fpga_data, shreg};
    assign hs = byte_valid && byte_ready;
    assign pop = state == HI && hs;
    assign many = word_count > CW'(1);
    // A word pushed on the popping edge counts as remaining, keeping the drain back-to-back.
    assign more = many || push;

    okand_sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) fifo (
        .clk(pc_clk),
        .rst(pc_rst),
        .push(push),
        .push_data(push_word),
        .pop(pop),
        .head(head),
        .head_next(head_next),
        .full(full),
        .empty(empty),
        .count(word_count)
    );

    always_ff @(posedge pc_clk) begin
        if (pc_rst) begin
            bit_cnt <= '0;
            shreg <= '0;
            frame_err <= 1'b0;
            overflow <= 1'b0;
        end else begin
            frame_err <= !fpga_valid && bit_cnt != 4'd0;
            if (fpga_valid) begin
                if (bit_cnt != 4'd15)
                    shreg[bit_cnt] <= fpga_data;
                bit_cnt <= bit_cnt + 4'd1;
            end else begin
                bit_cnt <= '0;
            end
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge pc_clk) begin
        if (pc_rst) begin
            state <= IDLE;
            byte_data <= '0;
            byte_valid <= 1'b0;
        end else begin
            state <= state_d;
            byte_data <= data_d;
            byte_valid <= valid_d;
        end
    end

    always_comb begin
        state_d = (state == IDLE) ? (empty ? IDLE : LO)
                : (state == LO)   ? (hs ? HI : LO)
                :                   (hs ? (more ? LO : IDLE) : HI);
    end

    always_comb begin
        valid_d = state_d != IDLE;
        data_d = (state == IDLE && !empty) ? head[BYTE_W-1:0]
               : (state == LO && hs)       ? head[WORD_W-1:BYTE_W]
               : (pop && more)             ? (many ? head_next[BYTE_W-1:0] : push_word[BYTE_W-1:0])
               :                             byte_data;
    end
endmodule

// File: doc/okand_result_collector.md
# okand_result_collector

Deserializes the 16-bit result bursts emitted by the okand compute stage on `fpga_data`/`fpga_valid` into words and buffers them in a small FIFO. It drains them as little-endian byte pairs over a valid/ready byte interface to the downstream transmitter. It sits directly downstream of the compute stage, in the same `pc_clk` domain.

## Interface
- `DEPTH`, default 4: FIFO depth in 16-bit words; power of two, ≥2.
- `pc_clk`  in  1  sole clock, rising edge.
- `pc_rst`  in  1  synchronous reset, active-high.
- `fpga_data`  in  1  result bit from the compute stage, LSB first.
- `fpga_valid`  in  1  qualifies `fpga_data`; a burst is 16 consecutive high cycles.
- `byte_data`  out  8  byte to transmitter.
- `byte_valid`  out  1  `byte_data` valid.
- `byte_ready`  in  1  transmitter accepts the byte; handshake = `byte_valid && byte_ready` at a rising edge.
- `word_count`  out  $clog2(DEPTH)+1  words held in the FIFO, including the word being drained.
- `overflow`  out  1  sticky: a completed word was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse: the burst ended short of 16 bits.

## Operation
- Deserializer:
  - 4-bit `bit_cnt` and a 15-bit shift register.
  - Each cycle with `fpga_valid`=1, the bit goes to word position `bit_cnt`, then `bit_cnt`+1.
  - When `bit_cnt`=15 and valid, the 16-bit word (15 stored bits plus incoming bit) is pushed at that edge and `bit_cnt` wraps to 0.
- Short frame:
  - Condition: `fpga_valid`=0 while `bit_cnt`≠0.
  - Action: partial word discarded, `bit_cnt`→0, `frame_err`=1 for exactly the next cycle.
- Full FIFO:
  - A push when full and no same-edge pop drops the word, sets `overflow`, and leaves the FIFO unchanged.
  - `overflow` clears only on `pc_rst`.
- Drain FSM, states IDLE, LO, HI:
  - IDLE: if FIFO non-empty → LO, drive the head word's low byte, set `byte_valid`.
  - LO: on handshake → HI, drive the head's high byte.
  - HI: on handshake, pop the head. If words remain after the pop → LO with the new head's low byte (back-to-back). Otherwise → IDLE, `byte_valid`=0.
  - `byte_data` is held stable while `byte_valid && !byte_ready`.
  - All outputs are registered.
- Simultaneous push and pop when full (HI handshake on the same edge as the 16th bit): push accepted, no overflow, `word_count` unchanged.
- `word_count` is incremented by a push, decremented by a pop, and unchanged when both occur.

## Timing
- Reset values: `byte_data`=0, `byte_valid`=0, `word_count`=0, `overflow`=0, `frame_err`=0. FIFO empty, `bit_cnt`=0, FSM IDLE.
- Reset mid-burst discards the partial word.
- Reset mid-drain drops all buffered words; `byte_valid`=0 in the cycle after reset.
- If `fpga_valid` is still high when reset releases, counting restarts at the first valid cycle. There is no realignment; the resulting short tail is reported via `frame_err`.
- Latency: last bit presented in cycle c → `word_count` updated in c+1 → low byte `byte_valid` in c+2 (FIFO empty, FSM IDLE beforehand).
- Throughput with `byte_ready`=1 steady: one byte per cycle. Both bytes of a word take 2 cycles, well under the 16-cycle burst period.

## Structure
- Package `okand_pkg`:
  - `WORD_W`=16, `BYTE_W`=8.
  - `drain_state_t` enum {IDLE, LO, HI}.
- Sub-module `okand_sync_fifo`:
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop, full/empty/count.
  - First-word-fall-through head output.
  - Same-edge push+pop allowed when full.
- Top contains the deserializer and drain FSM.

## Test plan
- Single burst of 0xA5C3 LSB first, `byte_ready`=1 → 0xC3 in cycle c+2, 0xA5 in c+3, then `byte_valid`=0 and `word_count`=0.
- Same burst, `byte_ready` low for 5 cycles after `byte_valid` rises → `byte_data` held at 0xC3 with `byte_valid`=1 throughout; 0xA5 follows the first handshake.
- Five bursts 0x0001..0x0005, `byte_ready`=0, DEPTH=4:
  - `word_count`=4, `overflow`=1 after the 5th burst.
  - Release ready → bytes 01,00,02,00,03,00,04,00; `overflow` stays 1.
- `fpga_valid` high 7 cycles then low → `frame_err` high exactly one cycle, no bytes emitted. A following 0x1234 burst yields 0x34, 0x12.
- FIFO full, high-byte handshake aligned to the 16th bit of a new burst → no overflow, `word_count` stays 4, new word drained last.
- `pc_rst` during HI with 3 words buffered → next cycle `byte_valid`=0 and `word_count`=0; a subsequent burst of 0xBEEF yields 0xEF, 0xBE.
